// File: rtl/pio_blink_irq_if.sv
// Avalon-MM slave bus bundle for pio_blink_irq: word address, select,
// active-low write strobe, write data and combinational read data.
interface pio_blink_irq_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/pio_blink_irq.sv
// Avalon-MM GPIO slave: output register with atomic set/clear and per-bit
// hardware blink, synchronised inputs with rising-edge capture and a
// maskable level interrupt. Zero wait states, reads have no side effects.
module pio_blink_irq #(
    parameter int unsigned           OUT_WIDTH  = 2,
    parameter int unsigned           IN_WIDTH   = 2,
    parameter int unsigned           DIV_WIDTH  = 24,
    parameter logic [OUT_WIDTH-1:0]  DATA_RESET = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pio_blink_irq_if.slave       bus,
    input  logic [IN_WIDTH-1:0]  in_port,
    output logic [OUT_WIDTH-1:0] out_port,
    output logic                 irq
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_INDATA   = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK  = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP  = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
    localparam logic [2:0] ADDR_BLINKEN  = 3'd6;
    localparam logic [2:0] ADDR_BLINKDIV = 3'd7;

    logic [OUT_WIDTH-1:0] data_out_q, data_out_d;
    logic [OUT_WIDTH-1:0] blinken_q, blinken_d;
    logic [DIV_WIDTH-1:0] blinkdiv_q, blinkdiv_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic                 phase_q, phase_d;
    logic [IN_WIDTH-1:0]  irqmask_q, irqmask_d;
    logic [IN_WIDTH-1:0]  edgecap_q, edgecap_d;
    logic [IN_WIDTH-1:0]  sync1_q, sync2_q, prev_q;
    logic [IN_WIDTH-1:0]  rise;
    logic [IN_WIDTH-1:0]  edge_clr;
    logic                 wr;

    assign wr   = bus.chipselect & ~bus.write_n;
    assign rise = sync2_q & ~prev_q;

    // Register-file write decode and next-state for the software-visible registers
    always_comb begin
        data_out_d = data_out_q;
        blinken_d  = blinken_q;
        blinkdiv_d = blinkdiv_q;
        irqmask_d  = irqmask_q;
        edge_clr   = '0;
        if (wr) begin
            case (bus.address)
                ADDR_DATA:     data_out_d = bus.writedata[OUT_WIDTH-1:0];
                ADDR_IRQMASK:  irqmask_d  = bus.writedata[IN_WIDTH-1:0];
                ADDR_EDGECAP:  edge_clr   = bus.writedata[IN_WIDTH-1:0];
                ADDR_OUTSET:   data_out_d = data_out_q | bus.writedata[OUT_WIDTH-1:0];
                ADDR_OUTCLEAR: data_out_d = data_out_q & ~bus.writedata[OUT_WIDTH-1:0];
                ADDR_BLINKEN:  blinken_d  = bus.writedata[OUT_WIDTH-1:0];
                ADDR_BLINKDIV: blinkdiv_d = bus.writedata[DIV_WIDTH-1:0];
                default: ;
            endcase
        end
        // A new rise on the same cycle as a clear keeps the bit set
        edgecap_d = (edgecap_q & ~edge_clr) | rise;
    end

    // Blink divider: half-period of BLINKDIV+1 cycles, restarted by any BLINKDIV write
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (wr && (bus.address == ADDR_BLINKDIV)) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (blinkdiv_q == '0) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == blinkdiv_q) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + DIV_WIDTH'(1);
        end
    end

    // State registers, including the input synchroniser and edge-detect history
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q <= DATA_RESET;
            blinken_q  <= '0;
            blinkdiv_q <= '0;
            cnt_q      <= '0;
            phase_q    <= 1'b0;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
        end else begin
            data_out_q <= data_out_d;
            blinken_q  <= blinken_d;
            blinkdiv_q <= blinkdiv_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
        end
    end

    // Combinational read mux, zero-extended; set/clear ports read as zero
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA:     bus.readdata = 32'(data_out_q);
            ADDR_INDATA:   bus.readdata = 32'(sync2_q);
            ADDR_IRQMASK:  bus.readdata = 32'(irqmask_q);
            ADDR_EDGECAP:  bus.readdata = 32'(edgecap_q);
            ADDR_BLINKEN:  bus.readdata = 32'(blinken_q);
            ADDR_BLINKDIV: bus.readdata = 32'(blinkdiv_q);
            default:       bus.readdata = '0;
        endcase
    end

    // Outputs: blinking bits use DATA as idle polarity
    always_comb begin
        out_port = data_out_q ^ (blinken_q & {OUT_WIDTH{phase_q}});
        irq      = |(edgecap_q & irqmask_q);
    end

endmodule

// File: tb/tb_pio_blink_irq.sv
// Self-checking bench for pio_blink_irq (OUT_WIDTH=2, IN_WIDTH=2, DATA_RESET=2'b10).
// Expected values are queued when stimulus is driven and compared when sampled.
module tb_pio_blink_irq;

    localparam int K_RD  = 0;
    localparam int K_OUT = 1;
    localparam int K_IRQ = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] in_port;
    logic [1:0] out_port;
    logic       irq;

    pio_blink_irq_if bus ();

    pio_blink_irq #(
        .OUT_WIDTH  (2),
        .IN_WIDTH   (2),
        .DIV_WIDTH  (24),
        .DATA_RESET (2'b10)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .in_port  (in_port),
        .out_port (out_port),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        string       name;
        logic [31:0] value;
    } exp_t;

    typedef struct {
        bit          is_wr;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic [1:0]  exp_out;
        logic        exp_irq;
        string       name;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic expect_val(input int kind, input string name, input logic [31:0] value);
        exp_t e;
        e.kind  = kind;
        e.name  = name;
        e.value = value;
        sb.push_back(e);
    endtask

    // Sample 1 ns after stimulus settles and compare everything queued
    task automatic drain();
        exp_t        e;
        logic [31:0] act;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_RD:    act = bus.readdata;
                K_OUT:   act = {30'b0, out_port};
                default: act = {31'b0, irq};
            endcase
            checks++;
            if (act !== e.value) begin
                errors++;
                $display("FAIL %s: got 0x%08h, want 0x%08h", e.name, act, e.value);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 3'd0;
        bus.writedata  = 32'h0;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
        step();
        bus_idle();
    endtask

    task automatic bus_read_setup(input logic [2:0] a);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        bus.address    = a;
    endtask

    task automatic check_read(input logic [2:0] a, input logic [31:0] v, input string name);
        bus_read_setup(a);
        expect_val(K_RD, name, v);
        drain();
    endtask

    function automatic vec_t mk(input bit w, input int a, input int unsigned d,
                                input int unsigned r, input int o, input string n);
        vec_t v;
        v.is_wr   = w;
        v.addr    = a[2:0];
        v.data    = d;
        v.exp_rd  = r;
        v.exp_out = o[1:0];
        v.exp_irq = 1'b0;
        v.name    = n;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_idle();
        in_port = 2'b00;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Register map vectors
        vecs.push_back(mk(0, 0, 0,          32'h2, 2'b10, "rst_data"));
        vecs.push_back(mk(0, 1, 0,          32'h0, 2'b10, "rst_indata"));
        vecs.push_back(mk(0, 2, 0,          32'h0, 2'b10, "rst_irqmask"));
        vecs.push_back(mk(0, 3, 0,          32'h0, 2'b10, "rst_edgecap"));
        vecs.push_back(mk(0, 6, 0,          32'h0, 2'b10, "rst_blinken"));
        vecs.push_back(mk(0, 7, 0,          32'h0, 2'b10, "rst_blinkdiv"));
        vecs.push_back(mk(1, 0, 32'h1,      32'h0, 2'b01, "wr_data"));
        vecs.push_back(mk(1, 4, 32'h2,      32'h0, 2'b11, "wr_outset"));
        vecs.push_back(mk(1, 5, 32'h1,      32'h0, 2'b10, "wr_outclear"));
        vecs.push_back(mk(0, 4, 0,          32'h0, 2'b10, "rd_outset"));
        vecs.push_back(mk(0, 5, 0,          32'h0, 2'b10, "rd_outclear"));
        vecs.push_back(mk(0, 0, 0,          32'h2, 2'b10, "rd_data"));
        vecs.push_back(mk(1, 1, 32'hffffffff, 32'h0, 2'b10, "wr_indata"));
        vecs.push_back(mk(0, 1, 0,          32'h0, 2'b10, "rd_indata_ro"));
        vecs.push_back(mk(1, 2, 32'hffffffff, 32'h0, 2'b10, "wr_irqmask"));
        vecs.push_back(mk(0, 2, 0,          32'h3, 2'b10, "rd_irqmask"));
        vecs.push_back(mk(1, 6, 32'h1,      32'h0, 2'b10, "wr_blinken_div0"));
        vecs.push_back(mk(0, 6, 0,          32'h1, 2'b10, "rd_blinken"));
        vecs.push_back(mk(1, 2, 32'h0,      32'h0, 2'b10, "wr_irqmask0"));
        vecs.push_back(mk(1, 6, 32'h0,      32'h0, 2'b10, "wr_blinken0"));

        foreach (vecs[i]) begin
            if (vecs[i].is_wr) begin
                bus_write(vecs[i].addr, vecs[i].data);
            end else begin
                bus_read_setup(vecs[i].addr);
                expect_val(K_RD, {vecs[i].name, "_rd"}, vecs[i].exp_rd);
            end
            expect_val(K_OUT, {vecs[i].name, "_out"}, {30'b0, vecs[i].exp_out});
            expect_val(K_IRQ, {vecs[i].name, "_irq"}, {31'b0, vecs[i].exp_irq});
            drain();
            if (!vecs[i].is_wr) begin
                step();
                bus_idle();
            end
        end

        // Blink: DATA=2'b10, BLINKEN=1, BLINKDIV=3 -> bit 0 toggles every 4 edges
        bus_write(3'd0, 32'h2);
        bus_write(3'd6, 32'h1);
        bus_write(3'd7, 32'h3);
        bus_read_setup(3'd7);
        for (int c = 0; c <= 12; c++) begin
            expect_val(K_OUT, $sformatf("blink_c%0d", c), {30'b0, 1'b1, 1'(((c / 4) % 2) != 0)});
            expect_val(K_RD, "blink_div_rd", 32'h3);
            drain();
            if (c < 12) step();
        end
        bus_write(3'd7, 32'h0);
        expect_val(K_OUT, "blink_stop", 32'h2);
        drain();
        step();
        expect_val(K_OUT, "blink_stop_hold", 32'h2);
        drain();
        bus_write(3'd6, 32'h0);

        // Edge capture and interrupt latency
        bus_write(3'd2, 32'h1);
        in_port = 2'b01;
        step();
        check_read(3'd1, 32'h0, "indata_k");
        step();
        check_read(3'd1, 32'h1, "indata_k1");
        expect_val(K_IRQ, "irq_k1", 32'h0);
        check_read(3'd3, 32'h0, "edgecap_k1");
        step();
        check_read(3'd3, 32'h1, "edgecap_k2");
        expect_val(K_IRQ, "irq_k2", 32'h1);
        drain();
        bus_idle();

        // Mask gates irq without touching EDGECAP
        bus_write(3'd2, 32'h0);
        expect_val(K_IRQ, "irq_masked", 32'h0);
        drain();
        check_read(3'd3, 32'h1, "edgecap_kept");
        bus_idle();
        bus_write(3'd2, 32'h1);
        expect_val(K_IRQ, "irq_unmasked", 32'h1);
        drain();

        // Clear, then a held-high input must not recapture
        bus_write(3'd3, 32'h1);
        expect_val(K_IRQ, "irq_cleared", 32'h0);
        drain();
        for (int c = 0; c < 3; c++) begin
            step();
            check_read(3'd3, 32'h0, "no_recapture");
            expect_val(K_IRQ, "no_recapture_irq", 32'h0);
            drain();
        end
        bus_idle();

        // Clear write landing on the same edge as a new capture: set wins
        in_port = 2'b00;
        repeat (4) step();
        in_port = 2'b01;
        step();
        step();
        bus_write(3'd3, 32'h1);
        check_read(3'd3, 32'h1, "setclr_collide");
        expect_val(K_IRQ, "setclr_irq", 32'h1);
        drain();
        bus_idle();

        // Asynchronous reset mid-blink with EDGECAP set and irq high
        bus_write(3'd0, 32'h0);
        bus_write(3'd6, 32'h1);
        bus_write(3'd7, 32'h2);
        repeat (2) step();
        #2;
        reset_n = 1'b0;
        bus_read_setup(3'd0);
        expect_val(K_RD, "async_rst_data", 32'h2);
        expect_val(K_OUT, "async_rst_out", 32'h2);
        expect_val(K_IRQ, "async_rst_irq", 32'h0);
        drain();
        step();
        check_read(3'd3, 32'h0, "rst_hold_edgecap");
        check_read(3'd7, 32'h0, "rst_hold_blinkdiv");
        step();
        check_read(3'd6, 32'h0, "rst_hold_blinken");
        reset_n = 1'b1;
        bus_idle();

        // After release the still-high input is seen as one fresh edge
        step();
        expect_val(K_OUT, "post_rst_out1", 32'h2);
        drain();
        step();
        check_read(3'd3, 32'h0, "post_rst_edge2");
        expect_val(K_OUT, "post_rst_out2", 32'h2);
        drain();
        step();
        check_read(3'd3, 32'h1, "post_rst_edge3");
        expect_val(K_IRQ, "post_rst_irq", 32'h0);
        drain();
        bus_idle();

        // Counter restarts cleanly: BLINKDIV=1 toggles 2 edges after the write
        bus_write(3'd6, 32'h1);
        bus_write(3'd7, 32'h1);
        expect_val(K_OUT, "restart_c0", 32'h2);
        drain();
        step();
        expect_val(K_OUT, "restart_c1", 32'h2);
        drain();
        step();
        expect_val(K_OUT, "restart_c2", 32'h3);
        drain();
        step();
        step();
        expect_val(K_OUT, "restart_c4", 32'h2);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pio_blink_irq.md
# pio_blink_irq

Parametrised Avalon-MM general-purpose I/O slave for the NIOS II core system: the successor to the fixed 2-bit output PIO. It provides a width-configurable output register with atomic set/clear and a per-bit hardware blink mode driven by a programmable divider. It also provides a synchronised input port with rising-edge capture and a maskable level interrupt. It sits on the core's data master as a zero-wait-state slave and drives board LEDs and buttons directly.

## Interface
- OUT_WIDTH, 2, number of output bits (1..32)
- IN_WIDTH, 2, number of input bits (1..32)
- DIV_WIDTH, 24, width of blink divider register (1..32)
- DATA_RESET, 0, reset value of DATA register (OUT_WIDTH bits)

- clk  in  1  system clock; all state on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- address  in  3  word register index
- chipselect  in  1  slave select
- write_n  in  1  write strobe, active-low, qualified by chipselect
- writedata  in  32  write data
- readdata  out  32  read data, combinational, zero-extended
- in_port  in  IN_WIDTH  asynchronous external inputs
- out_port  out  OUT_WIDTH  external outputs
- irq  out  1  level interrupt, active-high

## Operation
- Write occurs when chipselect=1 and write_n=0; the addressed register updates on that rising edge. Reads have no side effects.
- Register map (R / W):
  - 0 DATA: R data_out; W data_out <= writedata[OUT_WIDTH-1:0]
  - 1 INDATA: R sync2 (synchronised in_port); W ignored
  - 2 IRQMASK: R/W, IN_WIDTH bits
  - 3 EDGECAP: R captured edges; W 1-to-clear per bit
  - 4 OUTSET: R 0; W data_out <= data_out | wd
  - 5 OUTCLEAR: R 0; W data_out <= data_out & ~wd
  - 6 BLINKEN: R/W, OUT_WIDTH bits
  - 7 BLINKDIV: R/W, DIV_WIDTH bits
- Unused readdata bits read 0.
- Blink engine:
  - Counter cnt (DIV_WIDTH) and phase bit.
  - If BLINKDIV=0: cnt=0, phase=0 held.
  - Otherwise cnt increments each cycle. When cnt==BLINKDIV: cnt<=0, phase<=~phase. The half-period is therefore BLINKDIV+1 cycles.
  - A write to BLINKDIV forces cnt<=0 and phase<=0 on the same edge.
- out_port[i] = BLINKEN[i] ? data_out[i]^phase : data_out[i]. Blinking bits keep their DATA value as the idle polarity.
- Input path: in_port -> sync1 -> sync2 -> prev (all flops). rise = sync2 & ~prev.
- EDGECAP[i] <= (EDGECAP[i] & ~clr[i]) | rise[i], where clr is the EDGECAP write data. When a set and a clear hit the same bit in the same cycle, set wins.
- irq = |(EDGECAP & IRQMASK), combinational from registers.
- Reset values: data_out=DATA_RESET, IRQMASK=0, EDGECAP=0, BLINKEN=0, BLINKDIV=0, cnt=0, phase=0.
  - sync1, sync2 and prev reset to 0. An input high at reset release therefore captures one edge.
  - Outputs at reset: out_port=DATA_RESET, irq=0, readdata per the map.

## Timing
- Register writes are visible on readdata and out_port in the cycle after the write edge.
- readdata is valid in the same cycle that address is presented (0 wait states).
- An in_port change sampled at edge k reaches sync2 after edge k+1, so INDATA reflects it after edge k+1.
- A rising edge is captured into EDGECAP at edge k+2. irq asserts in that same cycle if the bit is masked in.
- Blink: after a BLINKDIV=N write at edge w (N>0), phase toggles at edges w+N+1, w+2(N+1), and so on.
- Clearing IRQMASK deasserts irq combinationally in the next cycle without altering EDGECAP.
- Asserting reset_n=0 mid-operation clears all state immediately, without waiting for clk. On release, operation restarts from reset values.

## Test plan
- Reset with DATA_RESET=2'b10 -> out_port=2'b10, irq=0. Read addr 0 -> 0x00000002; addrs 2,3,6,7 -> 0.
- Write DATA=0x1, OUTSET=0x2, then OUTCLEAR=0x1 -> out_port goes 01, 11, 10. Reads of addrs 4 and 5 return 0.
- BLINKDIV=3, BLINKEN=0x1, DATA=0 -> out_port[0] toggles every 4 cycles (first toggle 4 cycles after the BLINKDIV write) while out_port[1] stays steady. BLINKDIV=0 -> out_port[0] returns to DATA[0].
- IRQMASK=0x1, in_port[0] 0->1 -> EDGECAP=0x1 and irq=1 at the third edge after the change. Write EDGECAP=0x1 -> irq=0. Holding in_port high produces no re-capture.
- EDGECAP clear write in the same cycle as a new rise on bit 0 -> bit stays 1 and irq stays 1.
- Pulse reset_n low mid-blink with EDGECAP set -> all outputs return to reset values asynchronously, and the counter restarts from 0 after release.
